// File: rtl/spi_controller.sv
// SPI initiator for the two-byte register protocol, all four CPOL/CPHA modes.
// Optional build macro SPI_CTRL_GUARD_EN stretches cs_n setup/hold to GUARD cycles.
module spi_controller #(
    parameter int unsigned REG_W    = 8,
    parameter int unsigned HALF_DIV = 4,
    parameter int unsigned GUARD    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             wr_rdn,
    input  logic [REG_W-2:0] addr,
    input  logic [REG_W-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] status,
    output logic [REG_W-1:0] rdata,
    output logic             spi_clk,
    output logic             spi_cs_n,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int unsigned FW    = 2 * REG_W;
    localparam int unsigned NHALF = 4 * REG_W;
`ifdef SPI_CTRL_GUARD_EN
    localparam int unsigned H_SET = GUARD;
`else
    localparam int unsigned H_SET = HALF_DIV;
`endif
    localparam int unsigned CMAX  = (H_SET > HALF_DIV) ? H_SET : HALF_DIV;
    localparam int unsigned CW    = $clog2(CMAX) + 1;
    localparam int unsigned HW    = $clog2(NHALF);
    localparam int unsigned BW    = $clog2(FW);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    half_q, half_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [FW-1:0]    tx_q, tx_d;
    logic [FW-1:0]    rx_q, rx_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [REG_W-1:0] status_q, status_d;
    logic [REG_W-1:0] rdata_q, rdata_d;
    logic             clk_q, clk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;

    logic             edge_go;
    logic [HW-1:0]    edge_idx;
    logic             lead;
    logic             no_adv;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        busy_d   = busy_q;
        done_d   = done_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        clk_d    = clk_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        edge_go  = 1'b0;
        edge_idx = '0;
        lead     = 1'b0;
        no_adv   = 1'b0;

        if (ena) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_d = mode[1];
                    // The cycle showing done is still IDLE but must not accept a new frame.
                    if (start && !done_q) begin
                        state_d = S_SETUP;
                        busy_d  = 1'b1;
                        cs_n_d  = 1'b0;
                        cpol_d  = mode[1];
                        cpha_d  = mode[0];
                        tx_d    = {wr_rdn, addr, wdata};
                        mosi_d  = wr_rdn;
                        rx_d    = '0;
                        cnt_d   = '0;
                        half_d  = '0;
                        bit_d   = '0;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == CW'(H_SET - 1)) begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                        half_d  = '0;
                        edge_go = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == CW'(HALF_DIV - 1)) begin
                        cnt_d = '0;
                        if (half_q == HW'(NHALF - 1)) begin
                            state_d = S_HOLD;
                        end else begin
                            half_d   = half_q + HW'(1);
                            edge_go  = 1'b1;
                            edge_idx = half_q + HW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_q == CW'(H_SET - 1)) begin
                        state_d  = S_GAP;
                        cnt_d    = '0;
                        cs_n_d   = 1'b1;
                        status_d = rx_q[FW-1:REG_W];
                        rdata_d  = rx_q[REG_W-1:0];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CW'(HALF_DIV - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Each half-period opens with a spi_clk edge; even indices are leading edges.
            if (edge_go) begin
                clk_d = ~clk_q;
                lead  = ~edge_idx[0];
                if (lead ^ cpha_q) begin
                    rx_d = {rx_q[FW-2:0], spi_miso};
                    if (bit_q != BW'(FW - 1)) begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    no_adv = cpha_q ? (edge_idx == '0) : (edge_idx == HW'(NHALF - 1));
                    if (!no_adv) begin
                        tx_d   = {tx_q[FW-2:0], 1'b0};
                        mosi_d = tx_q[FW-2];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            half_q   <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= '0;
            rdata_q  <= '0;
            clk_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            clk_q    <= clk_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign status   = status_q;
    assign rdata    = rdata_q;
    assign spi_clk  = clk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule
